running_diff_unpack: RTL

//  Inverse of the runningAdd1 running-sum stage. Accepts one packed word of LANES

---
 rtl/running_diff_unpack.sv | 121 ++++++++++++
 1 files changed

// File: rtl/running_diff_unpack.sv
// Running-sum decoder: unpacks LANES running sums and emits first differences one per cycle.
// Optional sample counter output enabled by defining RUNDIFF_CNT_EN.
module running_diff_unpack #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH*LANES-1:0] i_data,
    input  logic                        i_data_valid,
    output logic                        o_data_ready,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_data_valid,
    input  logic                        i_data_ready
`ifdef RUNDIFF_CNT_EN
    ,
    output logic [31:0]                 o_sample_count
`endif
);
    localparam int IW = $clog2(LANES + 1);

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] word_t;
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    word_t                 buf_q, buf_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  vld_q, vld_d;

    word_t                 in_word;
    logic [DATA_WIDTH-1:0] lane0, cur_lane;
    logic                  last_lane, accept, fire;

    assign in_word      = word_t'(i_data);
    assign lane0        = in_word[0];
    assign last_lane    = (idx_q == IW'(LANES));
    // Ready while the last lane drains lets the next word load with no bubble.
    assign o_data_ready = ~vld_q | (last_lane & i_data_ready);
    assign accept       = i_data_valid & o_data_ready;
    assign fire         = vld_q & i_data_ready;
    assign o_data       = data_q;
    assign o_data_valid = vld_q;

    always_comb begin
        cur_lane = '0;
        for (int k = 0; k < LANES; k++)
            if (idx_q == IW'(k)) cur_lane = buf_q[k];
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        prev_d  = prev_q;
        data_d  = data_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d   = in_word;
                    data_d  = lane0 - prev_q;
                    prev_d  = lane0;
                    idx_d   = IW'(1);
                    vld_d   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fire) begin
                    if (!last_lane) begin
                        data_d = cur_lane - prev_q;
                        prev_d = cur_lane;
                        idx_d  = idx_q + IW'(1);
                    end else if (accept) begin
                        buf_d  = in_word;
                        data_d = lane0 - prev_q;
                        prev_d = lane0;
                        idx_d  = IW'(1);
                    end else begin
                        vld_d   = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            prev_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

`ifdef RUNDIFF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     cnt_q <= '0;
        else if (fire) cnt_q <= cnt_q + 32'd1;
    end

    assign o_sample_count = cnt_q;
`endif

endmodule
